// File: rtl/myproject_mac_pkg.sv
// Shared constants and the output rounding/limiting function for the MAC pipeline.
package myproject_mac_pkg;

   localparam int NUM_STAGE_MIN = 1;
   localparam int NUM_STAGE_MAX = 4;
   // Working width of the rounding function; the accumulator must be strictly narrower.
   localparam int RND_W = 64;

   typedef struct packed {
      logic                    ovf;
      logic signed [RND_W-1:0] val;
   } rnd_res_t;

   // Round half up, drop `shift` fraction bits, then clamp (sat) or wrap to `dw` bits.
   function automatic rnd_res_t round_sat(input logic signed [RND_W-1:0] acc,
                                          input int shift, input int dw, input bit sat);
      logic signed [RND_W-1:0] one;
      logic signed [RND_W-1:0] sum;
      logic signed [RND_W-1:0] shr;
      logic signed [RND_W-1:0] hi;
      logic signed [RND_W-1:0] lo;
      logic signed [RND_W-1:0] wrapped;
      rnd_res_t                r;
      one     = 1;
      sum     = (shift > 0) ? acc + (one <<< (shift - 1)) : acc;
      shr     = sum >>> shift;
      hi      = (one <<< (dw - 1)) - one;
      lo      = ~hi;
      wrapped = (shr <<< (RND_W - dw)) >>> (RND_W - dw);
      r.ovf   = 1'b0;
      r.val   = shr;
      if (sat) begin
         if (shr > hi) begin
            r.val = hi;
            r.ovf = 1'b1;
         end else if (shr < lo) begin
            r.val = lo;
            r.ovf = 1'b1;
         end
      end else begin
         r.val = wrapped;
         r.ovf = (wrapped != shr);
      end
      return r;
   endfunction

endpackage

// File: rtl/myproject_mac_pipe_mult.sv
// NUM_STAGE-deep signed product pipeline carrying valid/last alongside the product.
module myproject_mac_pipe_mult
   import myproject_mac_pkg::*;
#(
   parameter int A_W       = 14,
   parameter int B_W       = 12,
   parameter int NUM_STAGE = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    in_valid,
   input  logic                    in_last,
   input  logic signed [A_W-1:0]   a,
   input  logic signed [B_W-1:0]   b,
   output logic                    out_valid,
   output logic                    out_last,
   output logic signed [A_W+B_W-1:0] prod
);

   localparam int P_W = A_W + B_W;

   logic signed [P_W-1:0] prod_q [NUM_STAGE];
   logic signed [P_W-1:0] prod_d [NUM_STAGE];
   logic [NUM_STAGE-1:0]  vld_q, vld_d;
   logic [NUM_STAGE-1:0]  last_q, last_d;

   always_comb begin
      prod_d = prod_q;
      vld_d  = vld_q;
      last_d = last_q;
      if (en) begin
         prod_d[0] = P_W'(a) * P_W'(b);
         vld_d[0]  = in_valid;
         last_d[0] = in_last;
         for (int i = 1; i < NUM_STAGE; i++) begin
            prod_d[i] = prod_q[i-1];
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
         vld_q  <= '0;
         last_q <= '0;
      end else begin
         prod_q <= prod_d;
         vld_q  <= vld_d;
         last_q <= last_d;
      end
   end

   assign out_valid = vld_q[NUM_STAGE-1];
   assign out_last  = last_q[NUM_STAGE-1];
   assign prod      = prod_q[NUM_STAGE-1];

endmodule

// File: rtl/myproject_mac_pipe.sv
// Streaming dot-product MAC: product pipeline, accumulator, round/limit stage, output register.
module myproject_mac_pipe
   import myproject_mac_pkg::*;
#(
   parameter int din0_WIDTH = 14,
   parameter int din1_WIDTH = 12,
   parameter int ACC_WIDTH  = 32,
   parameter int dout_WIDTH = 16,
   parameter int NUM_STAGE  = 2,
   parameter int SHIFT      = 8,
   parameter int SAT        = 1
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [din0_WIDTH-1:0] din0,
   input  logic signed [din1_WIDTH-1:0] din1,
   input  logic                         last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [dout_WIDTH-1:0] dout,
   output logic                         overflow
);

   localparam int PROD_W = din0_WIDTH + din1_WIDTH;

   if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_num_stage
      $error("myproject_mac_pipe: NUM_STAGE must be within 1..4");
   end
   if (ACC_WIDTH < PROD_W || ACC_WIDTH >= RND_W) begin : g_bad_acc_width
      $error("myproject_mac_pipe: ACC_WIDTH must cover din0_WIDTH+din1_WIDTH and stay below 64");
   end

   // Handshake: a beat transfers on an edge with in_valid && in_ready, a result on an edge
   // with out_valid && out_ready; every stage moves together only when in_ready is high.
   logic en;
   logic out_valid_q, out_valid_d;
   assign en       = ~out_valid_q | out_ready;
   assign in_ready = en;

   logic                     m_valid, m_last;
   logic signed [PROD_W-1:0] m_prod;

   myproject_mac_pipe_mult #(
      .A_W       (din0_WIDTH),
      .B_W       (din1_WIDTH),
      .NUM_STAGE (NUM_STAGE)
   ) u_mult (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .en        (en),
      .in_valid  (in_valid),
      .in_last   (last),
      .a         (din0),
      .b         (din1),
      .out_valid (m_valid),
      .out_last  (m_last),
      .prod      (m_prod)
   );

   logic signed [ACC_WIDTH-1:0]  prod_ext;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                         first_q, first_d;
   logic                         done_q, done_d;
   logic                         rnd_vld_q, rnd_vld_d;
   logic signed [dout_WIDTH-1:0] rnd_val_q, rnd_val_d;
   logic                         rnd_ovf_q, rnd_ovf_d;
   logic signed [dout_WIDTH-1:0] dout_q, dout_d;
   logic                         ovf_q, ovf_d;
   rnd_res_t                     rnd;
   logic                         unused_rnd_hi;

   assign prod_ext      = ACC_WIDTH'(m_prod);
   assign unused_rnd_hi = ^rnd.val[RND_W-1:dout_WIDTH];

   always_comb begin
      rnd = round_sat(RND_W'(acc_q), SHIFT, dout_WIDTH, SAT != 0);
   end

   // first_q marks that the next product starts a fresh vector instead of adding.
   always_comb begin
      acc_d       = acc_q;
      first_d     = first_q;
      done_d      = done_q;
      rnd_vld_d   = rnd_vld_q;
      rnd_val_d   = rnd_val_q;
      rnd_ovf_d   = rnd_ovf_q;
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      ovf_d       = ovf_q;
      if (en) begin
         done_d = 1'b0;
         if (m_valid) begin
            acc_d   = first_q ? prod_ext : acc_q + prod_ext;
            first_d = m_last;
            done_d  = m_last;
         end
         rnd_vld_d = done_q;
         if (done_q) begin
            rnd_val_d = rnd.val[dout_WIDTH-1:0];
            rnd_ovf_d = rnd.ovf;
         end
         out_valid_d = rnd_vld_q;
         if (rnd_vld_q) begin
            dout_d = rnd_val_q;
            ovf_d  = rnd_ovf_q;
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc_q       <= '0;
         first_q     <= 1'b1;
         done_q      <= 1'b0;
         rnd_vld_q   <= 1'b0;
         rnd_val_q   <= '0;
         rnd_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         ovf_q       <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         first_q     <= first_d;
         done_q      <= done_d;
         rnd_vld_q   <= rnd_vld_d;
         rnd_val_q   <= rnd_val_d;
         rnd_ovf_q   <= rnd_ovf_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Bench for myproject_mac_pipe: four instances (N=2 sat, N=2 wrap, N=1, N=4), one active at a time.
module tb_myproject_mac_pipe;

   localparam int NI = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid_s [NI];
   logic        last_s     [NI];
   logic        out_ready_s[NI];
   logic [13:0] din0_s     [NI];
   logic [11:0] din1_s     [NI];
   logic        in_ready_s [NI];
   logic        out_valid_s[NI];
   logic        ovf_s      [NI];
   logic [15:0] dout_s     [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      myproject_mac_pipe #(
         .NUM_STAGE ((g == 3) ? 4 : ((g == 2) ? 1 : 2)),
         .SAT       ((g == 1) ? 0 : 1)
      ) u_dut (
         .ap_clk    (clk),
         .ap_rst_n  (rst_n),
         .in_valid  (in_valid_s[g]),
         .in_ready  (in_ready_s[g]),
         .din0      (din0_s[g]),
         .din1      (din1_s[g]),
         .last      (last_s[g]),
         .out_valid (out_valid_s[g]),
         .out_ready (out_ready_s[g]),
         .dout      (dout_s[g]),
         .overflow  (ovf_s[g])
      );
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cur      = 0;
   bit          acc_seen;
   int          acc_m;
   bit          first_m;
   logic [16:0] exp_q[$];
   bit          prev_stall;
   logic [16:0] prev_out;

   // Reference: full-precision sum, round half up by 8 bits, then clamp or wrap to 16 bits.
   function automatic logic [16:0] model_result(input int acc, input bit sat);
      longint      r;
      logic [16:0] res;
      r = (longint'(acc) + 64'sd128) >>> 8;
      if (sat) begin
         if (r > 32767)       res = {1'b1, 16'h7FFF};
         else if (r < -32768) res = {1'b1, 16'h8000};
         else                 res = {1'b0, 16'(r)};
      end else begin
         res = {(r > 32767 || r < -32768), 16'(r)};
      end
      return res;
   endfunction

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         acc_m      = 0;
         first_m    = 1'b1;
         exp_q.delete();
         prev_stall = 1'b0;
         acc_seen   = 1'b0;
      end else begin
         acc_seen = in_valid_s[cur] && in_ready_s[cur];
         n_checks++;
         if (in_ready_s[cur] !== (!out_valid_s[cur] || out_ready_s[cur])) begin
            n_fail++;
            $display("FAIL in_ready inst=%0d got=%b want=%b", cur, in_ready_s[cur],
                     (!out_valid_s[cur] || out_ready_s[cur]));
         end
         if (prev_stall) begin
            n_checks++;
            if ({out_valid_s[cur], ovf_s[cur], dout_s[cur]} !== {1'b1, prev_out}) begin
               n_fail++;
               $display("FAIL stall_hold inst=%0d got=%b/%h want=1/%h", cur, out_valid_s[cur],
                        {ovf_s[cur], dout_s[cur]}, prev_out);
            end
         end
         if (acc_seen) begin
            int p;
            p = int'($signed(din0_s[cur])) * int'($signed(din1_s[cur]));
            acc_m   = first_m ? p : acc_m + p;
            first_m = last_s[cur];
            if (last_s[cur]) exp_q.push_back(model_result(acc_m, cur != 1));
         end
         if (out_valid_s[cur] && out_ready_s[cur]) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_result inst=%0d got=%h want=none", cur,
                        {ovf_s[cur], dout_s[cur]});
            end else begin
               logic [16:0] e;
               e = exp_q.pop_front();
               if ({ovf_s[cur], dout_s[cur]} !== e) begin
                  n_fail++;
                  $display("FAIL result inst=%0d got ovf/dout=%h want=%h", cur,
                           {ovf_s[cur], dout_s[cur]}, e);
               end
            end
         end
         prev_stall = out_valid_s[cur] && !out_ready_s[cur];
         prev_out   = {ovf_s[cur], dout_s[cur]};
      end
   end

   task automatic pulse_reset(input int inst);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      cur   = inst;
      for (int i = 0; i < NI; i++) begin
         in_valid_s[i]  = 1'b0;
         out_ready_s[i] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic send(input int a, input int b, input logic l);
      int n;
      n = 0;
      in_valid_s[cur] = 1'b1;
      din0_s[cur]     = 14'(a);
      din1_s[cur]     = 12'(b);
      last_s[cur]     = l;
      do begin
         @(posedge clk);
         n++;
      end while (!acc_seen && n < 50);
      n_checks++;
      if (!acc_seen) begin
         n_fail++;
         $display("FAIL beat_accept inst=%0d got=timeout want=accepted", cur);
      end
      #1;
   endtask

   task automatic wait_out(output logic [16:0] got, output int cyc);
      cyc = 0;
      while (!out_valid_s[cur] && cyc < 30) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      got = {ovf_s[cur], dout_s[cur]};
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid_s[cur]  = 1'b0;
      out_ready_s[cur] = 1'b1;
      while ((exp_q.size() != 0 || out_valid_s[cur]) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain inst=%0d got=%0d pending want=0", cur, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         n_checks++;
         if ({in_ready_s[i], out_valid_s[i], ovf_s[i], dout_s[i]} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_state inst=%0d got rdy/vld/ovf/dout=%b%b%b/%h want=100/0000", i,
                     in_ready_s[i], out_valid_s[i], ovf_s[i], dout_s[i]);
         end
      end
      pulse_reset(0);
   endtask

   task automatic test_latency();
      logic [16:0] got;
      int          cyc;
      pulse_reset(0);
      send(256, 256, 1'b0);
      send(256, 256, 1'b0);
      send(-256, 256, 1'b1);
      in_valid_s[cur] = 1'b0;
      wait_out(got, cyc);
      n_checks++;
      if (cyc !== 4) begin
         n_fail++;
         $display("FAIL latency got=%0d want=4", cyc);
      end
      n_checks++;
      if (got !== {1'b0, 16'd256}) begin
         n_fail++;
         $display("FAIL dot3 got=%h want=%h", got, {1'b0, 16'd256});
      end
      drain();
   endtask

   task automatic test_rounding();
      logic [16:0] got;
      int          cyc;
      pulse_reset(0);
      send(3, 128, 1'b1);
      in_valid_s[cur] = 1'b0;
      wait_out(got, cyc);
      n_checks++;
      if (got !== {1'b0, 16'd2}) begin
         n_fail++;
         $display("FAIL round_pos got=%h want=%h", got, {1'b0, 16'd2});
      end
      @(posedge clk);
      #1;
      send(-3, 128, 1'b1);
      in_valid_s[cur] = 1'b0;
      wait_out(got, cyc);
      n_checks++;
      if (got !== {1'b0, 16'hFFFF}) begin
         n_fail++;
         $display("FAIL round_neg got=%h want=%h", got, {1'b0, 16'hFFFF});
      end
      drain();
   endtask

   task automatic test_saturate(input int inst, input logic [16:0] want);
      logic [16:0] got;
      int          cyc;
      pulse_reset(inst);
      for (int i = 0; i < 4; i++) send(8191, 2047, (i == 3));
      in_valid_s[cur] = 1'b0;
      wait_out(got, cyc);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL limit inst=%0d got=%h want=%h", inst, got, want);
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [16:0] hold_v;
      pulse_reset(0);
      hold_v = '0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (c < 30) begin
            if (c == 0 || acc_seen) begin
               din0_s[cur] = 14'($urandom_range(0, 16383));
               din1_s[cur] = 12'($urandom_range(0, 4095));
               last_s[cur] = 1'b1;
            end
            in_valid_s[cur] = 1'b1;
         end else begin
            in_valid_s[cur] = 1'b0;
         end
         out_ready_s[cur] = !(c >= 12 && c < 17);
         #1;
         if (c >= 12 && c < 17) begin
            n_checks++;
            if ({out_valid_s[cur], in_ready_s[cur]} !== 2'b10) begin
               n_fail++;
               $display("FAIL stall_ready c=%0d got vld/rdy=%b%b want=10", c, out_valid_s[cur],
                        in_ready_s[cur]);
            end
            if (c == 12) hold_v = {ovf_s[cur], dout_s[cur]};
            else begin
               n_checks++;
               if ({ovf_s[cur], dout_s[cur]} !== hold_v) begin
                  n_fail++;
                  $display("FAIL stall_dout c=%0d got=%h want=%h", c, {ovf_s[cur], dout_s[cur]}, hold_v);
               end
            end
         end
      end
      drain();
   endtask

   task automatic test_reset_mid();
      logic [16:0] got;
      int          cyc;
      pulse_reset(0);
      send(100, 100, 1'b0);
      send(100, 100, 1'b0);
      in_valid_s[cur] = 1'b0;
      pulse_reset(0);
      send(5, 5, 1'b1);
      in_valid_s[cur] = 1'b0;
      wait_out(got, cyc);
      n_checks++;
      if (got !== {1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_mid got=%h want=%h", got, {1'b0, 16'd0});
      end
      drain();
   endtask

   task automatic test_random(input int inst, input int cycles);
      int rem, mid, c;
      bit stop;
      pulse_reset(inst);
      rem  = $urandom_range(1, 16);
      mid  = 0;
      c    = 0;
      stop = 1'b0;
      while (!stop) begin
         @(posedge clk);
         #1;
         c++;
         if (acc_seen) begin
            if (last_s[inst]) begin
               rem = $urandom_range(1, 16);
               mid = 0;
            end else begin
               rem--;
               mid++;
            end
            in_valid_s[inst] = 1'b0;
         end
         if (!in_valid_s[inst]) begin
            if (c < cycles || mid > 0) begin
               if ((mid > 0 && c >= cycles) || $urandom_range(0, 3) != 0) begin
                  in_valid_s[inst] = 1'b1;
                  if ($urandom_range(0, 1) == 1) begin
                     din0_s[inst] = 14'($urandom_range(0, 16383));
                     din1_s[inst] = 12'($urandom_range(0, 4095));
                  end else begin
                     din0_s[inst] = 14'($urandom_range(0, 511) - 256);
                     din1_s[inst] = 12'($urandom_range(0, 511) - 256);
                  end
                  last_s[inst] = (rem == 1);
               end
            end else begin
               stop = 1'b1;
            end
         end
         out_ready_s[inst] = ($urandom_range(0, 3) != 0);
         if (c > cycles + 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL random_bound inst=%0d got=%0d cycles want<=%0d", inst, c, cycles + 2000);
            stop = 1'b1;
         end
      end
      drain();
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         in_valid_s[i]  = 1'b0;
         last_s[i]      = 1'b0;
         out_ready_s[i] = 1'b1;
         din0_s[i]      = '0;
         din1_s[i]      = '0;
      end
      test_reset();
      test_latency();
      test_rounding();
      test_saturate(0, {1'b1, 16'h7FFF});
      test_saturate(1, {1'b1, 16'hFF60});
      test_backpressure();
      test_reset_mid();
      test_random(2, 400);
      test_random(3, 400);
      test_random(0, 300);
      test_random(1, 300);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
